// File: rtl/data_memory_hs_if.sv
// data_memory_hs_if: request/response handshake between the MEM-stage controller and the data memory
interface data_memory_hs_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
);
    logic req_valid;
    logic req_ready;
    logic req_write;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH/8-1:0] req_be;
    logic resp_valid;
    logic resp_ready;
    logic [DATA_WIDTH-1:0] resp_rdata;
    logic resp_err;
    modport master (
        output req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        input req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input req_valid, req_write, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_memory_hs.sv
// data_memory_hs: byte-enabled word memory behind a one-outstanding valid/ready handshake with fixed latency
module data_memory_hs #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH = 1024,
    parameter int ADDR_WIDTH = 32,
    parameter int LATENCY = 2
) (
    input logic clk,
    input logic rst_n,
    data_memory_hs_if.slave bus
);
    localparam int NB = DATA_WIDTH / 8;
    localparam int B = $clog2(NB);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    localparam logic [1:0] IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2;
    localparam logic [DATA_WIDTH-1:0] W0 = DATA_WIDTH'(5);
    logic [1:0] state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] lat_idx, idx, src_idx;
    logic lat_err, lat_write, accept, err, to_resp, src_err, src_write;
    logic [DATA_WIDTH-1:0] wdata, rsrc, rdata_q;
    logic err_q;
    // Word 0 is stored XOR 5 so a zero power-up array reads back 5 there.
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    assign bus.req_ready = rst_n && state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err = err_q;
    always_comb begin
        accept = bus.req_valid && bus.req_ready;
        idx = IW'(bus.req_addr >> B);
        err = |(bus.req_addr & ADDR_WIDTH'((1 << B) - 1)) || |(bus.req_addr >> (IW + B));
        wdata = bus.req_wdata ^ (idx == '0 ? W0 : '0);
        to_resp = state == IDLE ? accept && LATENCY == 1 : state == WAIT && cnt == CW'(1);
        src_idx = state == IDLE ? idx : lat_idx;
        src_err = state == IDLE ? err : lat_err;
        src_write = state == IDLE ? bus.req_write : lat_write;
        rsrc = mem[src_idx] ^ (src_idx == '0 ? W0 : '0);
    end
    always_ff @(posedge clk)
        for (int i = 0; i < NB; i++)
            if (accept && bus.req_write && !err && bus.req_be[i])
                mem[idx][8*i +: 8] <= wdata[8*i +: 8];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            lat_idx <= '0;
            lat_err <= 1'b0;
            lat_write <= 1'b0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                lat_idx <= idx;
                lat_err <= err;
                lat_write <= bus.req_write;
            end
            if (state == WAIT)
                cnt <= cnt - 1'b1;
            if (accept)
                cnt <= CW'(LATENCY - 1);
            if (to_resp) begin
                rdata_q <= src_err || src_write ? '0 : rsrc;
                err_q <= src_err;
            end
            state <= to_resp ? RESP : accept ? WAIT : state == RESP && bus.resp_ready ? IDLE : state;
        end
endmodule
